// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU-side memory-mapped port of the buffered UART receiver.
//   load  : CPU write strobe for this address slot, 1 clk wide
//   in    : CPU write data (outM); bit 15 selects flush (1) or pop (0)
//   out   : {empty, overrun, ferr, perr, 4'b0, head[7:0]} returned as inM
//   avail : ~empty, for LED/debug use
// master = CPU / memory mux side, slave = receiver side.
interface uart_rx_fifo_if;
  logic        load;
  logic [15:0] in;
  logic [15:0] out;
  logic        avail;

  modport master (output load, output in, input out, input avail);
  modport slave  (input load, input in, output out, output avail);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffered UART receiver for the Hack memory-mapped I/O space.
// Deserialises 8-bit frames from rx into a DEPTH-entry FIFO and exposes the head
// byte plus sticky status flags to the CPU.
// Ports:
//   clk   : system clock, all state on rising edge
//   rstn  : asynchronous active-low reset
//   rx    : UART line, idle high, asynchronous to clk
//   bus   : uart_rx_fifo_if.slave (load, in, out, avail)
// Parameters: CLK_HZ, BAUD (CLKS_PER_BIT = CLK_HZ/BAUD), DEPTH (power of 2, 2..64).
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a parity state and
// perr flag; otherwise frames are 8N1 and out[12] is constant 0.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ = 33333333,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rx,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned ADDR_W       = $clog2(DEPTH);
  localparam int unsigned PTR_W        = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rxState_t;

  // Line synchroniser plus one delayed copy for start-edge detection
  logic rxMeta, rxS, rxPrev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  rxState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             cntZero;
  logic             pushReq;
  logic             ferrSet;
  logic             perrSet;
`ifdef UART_RX_PARITY_EN
  logic             parityBad, parityBadNext;
`endif

  assign cntZero = (cnt == '0);

  // Receiver state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
`ifdef UART_RX_PARITY_EN
      parityBad <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
`ifdef UART_RX_PARITY_EN
      parityBad <= parityBadNext;
`endif
    end
  end

  // Receiver next-state: every sample point sits at cnt==0, mid-bit
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    bitIdxNext    = bitIdx;
    shiftNext     = shiftReg;
    pushReq       = 1'b0;
    ferrSet       = 1'b0;
    perrSet       = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBadNext = parityBad;
`endif
    case (state)
      IDLE: begin
        if (rxPrev && !rxS) begin
          stateNext = START;
          cntNext   = CNT_HALF;
        end
      end
      START: begin
        if (!cntZero) begin
          cntNext = cnt - CNT_W'(1);
        end else if (!rxS) begin
          stateNext  = DATA;
          cntNext    = CNT_FULL;
          bitIdxNext = '0;
        end else begin
          // Start bit no longer low at mid-bit: treat as glitch
          stateNext = IDLE;
        end
      end
      DATA: begin
        if (!cntZero) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          shiftNext = {rxS, shiftReg[7:1]};
          cntNext   = CNT_FULL;
          if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!cntZero) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          // Even parity: the parity bit must equal the XOR of the data bits
          parityBadNext = (rxS != (^shiftReg));
          perrSet       = (rxS != (^shiftReg));
          cntNext       = CNT_FULL;
          stateNext     = STOP;
        end
      end
`endif
      STOP: begin
        if (!cntZero) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          stateNext = IDLE;
          if (rxS) begin
`ifdef UART_RX_PARITY_EN
            pushReq = !parityBad;
`else
            pushReq = 1'b1;
`endif
          end else begin
            ferrSet = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // FIFO storage and CPU access
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic             overrun, ferr, perr;
  logic             empty, full;
  logic             flush, doPop, pushOk, doWrite, dropFull;
  logic [7:0]       head;
  logic             unusedIn;

  assign empty    = (wp == rp);
  assign full     = (wp[PTR_W-1] != rp[PTR_W-1]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
  assign flush    = bus.load && bus.in[15];
  assign doPop    = bus.load && !bus.in[15] && !empty;
  assign pushOk   = pushReq && !flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign doWrite  = pushOk && (!full || doPop);
  assign dropFull = pushOk && full && !doPop;
  assign unusedIn = ^bus.in[14:0];

  always_ff @(posedge clk) begin
    if (doWrite) mem[wp[ADDR_W-1:0]] <= shiftReg;
  end

  // Pointers and sticky flags; flush takes priority over any same-cycle update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp      <= '0;
      rp      <= '0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (doWrite) wp <= wp + PTR_W'(1);
      if (flush) begin
        rp      <= wp;
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end else begin
        if (doPop)    rp      <= rp + PTR_W'(1);
        if (dropFull) overrun <= 1'b1;
        if (ferrSet)  ferr    <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        perr <= 1'b0;
    else if (flush)   perr <= 1'b0;
    else if (perrSet) perr <= 1'b1;
  end
`else
  logic unusedPerrSet;
  assign unusedPerrSet = perrSet;
  assign perr          = 1'b0;
`endif

  assign head      = empty ? 8'h00 : mem[rp[ADDR_W-1:0]];
  assign bus.out   = {empty, overrun, ferr, perr, 4'b0000, head};
  assign bus.avail = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (8N1, default parameters).
// A small behavioural model (byte queue plus flags) predicts the status word.
module tb_uart_rx_fifo;

  localparam int unsigned BIT_CLKS = 289;
  localparam int unsigned DEPTH    = 16;

  logic clk = 1'b0;
  logic rstn;
  logic rx;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] q[$];
  logic       mOvr;
  logic       mFerr;

  function automatic logic [15:0] expOut();
    logic [7:0] h;
    h = 8'h00;
    if (q.size() != 0) h = q[0];
    return {(q.size() == 0), mOvr, mFerr, 1'b0, 4'h0, h};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic modelPush(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else mOvr = 1'b1;
  endtask

  task automatic modelPop();
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // All drive tasks start and end 1 time unit after a rising edge
  task automatic sendBit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(stopBit);
    rx = 1'b1;
  endtask

  task automatic cpuWrite(input logic [15:0] d);
    bus.load = 1'b1;
    bus.in   = d;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.in   = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] partial;
    rstn     = 1'b0;
    rx       = 1'b1;
    bus.load = 1'b0;
    bus.in   = 16'h0000;
    mOvr     = 1'b0;
    mFerr    = 1'b0;
    partial  = 8'h0F;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1: reset state, idle line
    check("reset_out", bus.out, 16'h8000);
    check("reset_avail", {15'b0, bus.avail}, 16'h0000);
    idle(2);

    // 2: single frame, then pop; push lands 2749 clk after the start bit is driven
    fork
      sendFrame(8'h41, 1'b1);
      begin
        repeat (2700) @(posedge clk);
        #1;
        check("t2_before_stop", bus.out, expOut());
        repeat (50) @(posedge clk);
        #1;
        modelPush(8'h41);
        check("t2_after_stop", bus.out, expOut());
        check("t2_avail", {15'b0, bus.avail}, 16'h0001);
      end
    join
    cpuWrite(16'h0000);
    modelPop();
    check("t2_popped", bus.out, expOut());

    // 3: 17 back-to-back frames overfill the FIFO
    for (int b = 0; b <= 16; b++) begin
      modelPush(8'(b));
      sendFrame(8'(b), 1'b1);
    end
    idle(2);
    check("t3_overrun", bus.out, expOut());
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_head_%0d", i), bus.out, expOut());
      cpuWrite(16'h0000);
      modelPop();
    end
    check("t3_drained", bus.out, expOut());
    cpuWrite(16'h0000);
    check("t3_pop_empty", bus.out, expOut());
    cpuWrite(16'h8000);
    mOvr = 1'b0;
    check("t3_flush", bus.out, expOut());

    // 4: framing error, then flush clears it
    sendFrame(8'h55, 1'b0);
    idle(2);
    mFerr = 1'b1;
    check("t4_ferr", bus.out, expOut());
    cpuWrite(16'h8000);
    mFerr = 1'b0;
    check("t4_flush", bus.out, expOut());

    // 5: short low pulse is a glitch, no push
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(400);
    check("t5_glitch", bus.out, expOut());

    // 6: reset during bit 3 of a frame, then a clean frame
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(partial[i]);
    rx   = 1'b1;
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    q.delete();
    mOvr  = 1'b0;
    mFerr = 1'b0;
    check("t6_reset", bus.out, expOut());
    idle(5);
    modelPush(8'hA5);
    sendFrame(8'hA5, 1'b1);
    idle(2);
    check("t6_a5", bus.out, expOut());

    // Pop in the same cycle as the next push with one entry queued
    fork
      sendFrame(8'h3C, 1'b1);
      begin
        repeat (2748) @(posedge clk);
        #1;
        bus.load = 1'b1;
        bus.in   = 16'h0000;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
      end
    join
    modelPop();
    modelPush(8'h3C);
    check("t6_push_pop", bus.out, expOut());
    cpuWrite(16'h0000);
    modelPop();
    check("t6_final", bus.out, expOut());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
